// File: rtl/dqs_preamble_detector_mc.sv
// Multi-lane DQS read-preamble hunter: detect pulse one cycle after the final sampled bit; no backpressure (en_i arms/aborts).
// Optional build macro DQS_DET_STATS_EN adds saturating pulse counters (match/skew/timeout).
module dqs_preamble_detector_mc #(
  parameter int NUM_LANES = 2,
  parameter int MAX_LEN   = 16,
  parameter int TIMEOUT_W = 8,
  parameter int SKEW_MAX  = 2,
  localparam int LW       = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 en_i,
  input  logic [NUM_LANES-1:0] dqs_i,
  input  logic [2:0]           pre_amble_sett_i,
  input  logic [MAX_LEN-1:0]   pattern_i,
  input  logic [LW-1:0]        len_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  output logic                 pattern_detected_o,
  output logic [NUM_LANES-1:0] lane_detected_o,
  output logic                 skew_err_o,
  output logic                 timeout_o,
  output logic                 busy_o
`ifdef DQS_DET_STATS_EN
  ,
  output logic [15:0]          match_cnt_o,
  output logic [15:0]          skew_err_cnt_o,
  output logic [15:0]          timeout_cnt_o
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HUNT = 1'b1;

  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);
  localparam int            SW       = $clog2(SKEW_MAX + 1) + 1;
  localparam logic [SW-1:0] SKEW_LIM = SW'(SKEW_MAX);

  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LW-1:0] l);
    return (MAX_LEN'(1) << l) - MAX_LEN'(1);
  endfunction

  logic [0:0]           state_q, state_d;
  logic [MAX_LEN-1:0]   pat_q, pat_d;
  logic [LW-1:0]        len_q, len_d;
  logic [LW-1:0]        fill_q, fill_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic                 skew_act_q, skew_act_d;
  logic [SW-1:0]        skew_cnt_q, skew_cnt_d;
  logic [NUM_LANES-1:0] lane_q, lane_d;
  logic                 det_q, det_d;
  logic                 serr_q, serr_d;
  logic                 tout_q, tout_d;
  // The newest bit comes straight from dqs_i, so MAX_LEN-1 bits of history suffice.
  logic [MAX_LEN-2:0]   shift_q [NUM_LANES];
  logic                 shift_clr, shift_en;

  logic [LW-1:0]        sel_len;
  logic [MAX_LEN-1:0]   sel_pat;
  logic [MAX_LEN-1:0]   mask;
  logic                 fill_ok;
  logic [NUM_LANES-1:0] hit;
  logic [NUM_LANES-1:0] lane_new;
  logic                 first_edge;
  logic [SW-1:0]        skew_k;
  logic                 skew_expire;

  always_comb begin
    sel_len = LW'(2);
    sel_pat = MAX_LEN'(2'b10);
    case (pre_amble_sett_i)
      3'b001: begin sel_len = LW'(4); sel_pat = MAX_LEN'(4'b0010);     end
      3'b010: begin sel_len = LW'(4); sel_pat = MAX_LEN'(4'b1110);     end
      3'b011: begin sel_len = LW'(6); sel_pat = MAX_LEN'(6'b000010);   end
      3'b100: begin sel_len = LW'(8); sel_pat = MAX_LEN'(8'b00001010); end
      3'b101: begin
        if (len_i < LW'(2))       sel_len = LW'(2);
        else if (len_i > LEN_MAX) sel_len = LEN_MAX;
        else                      sel_len = len_i;
        sel_pat = pattern_i & len_mask(sel_len);
      end
      default: begin sel_len = LW'(2); sel_pat = MAX_LEN'(2'b10); end
    endcase
  end

  // A lane needs at least len_q real samples since arm, so zero-filled history never matches.
  always_comb begin
    mask    = len_mask(len_q);
    fill_ok = (fill_q >= (len_q - LW'(1)));
    hit     = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      hit[n] = fill_ok && ((({shift_q[n], dqs_i[n]}) & mask) == pat_q);
    end
  end

  assign lane_new    = lane_q | hit;
  assign first_edge  = (lane_q == '0) && (hit != '0);
  assign skew_k      = first_edge ? '0 : skew_cnt_q;
  assign skew_expire = (first_edge || skew_act_q) && (skew_k >= SKEW_LIM);

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    len_d      = len_q;
    fill_d     = fill_q;
    tmo_d      = tmo_q;
    skew_act_d = skew_act_q;
    skew_cnt_d = skew_cnt_q;
    lane_d     = lane_q;
    det_d      = 1'b0;
    serr_d     = 1'b0;
    tout_d     = 1'b0;
    shift_clr  = 1'b0;
    shift_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d    = HUNT;
          pat_d      = sel_pat;
          len_d      = sel_len;
          fill_d     = '0;
          tmo_d      = timeout_i;
          skew_act_d = 1'b0;
          skew_cnt_d = '0;
          lane_d     = '0;
          shift_clr  = 1'b1;
        end
      end
      default: begin
        if (!en_i) begin
          state_d    = IDLE;
          lane_d     = '0;
          skew_act_d = 1'b0;
        end else begin
          shift_en = 1'b1;
          lane_d   = lane_new;
          fill_d   = (fill_q == LEN_MAX) ? fill_q : fill_q + LW'(1);
          tmo_d    = (tmo_q != '0) ? tmo_q - TIMEOUT_W'(1) : tmo_q;
          // Exit priority: detect, then skew window, then timeout.
          if (&lane_new) begin
            det_d      = 1'b1;
            state_d    = IDLE;
            skew_act_d = 1'b0;
          end else if (skew_expire) begin
            serr_d     = 1'b1;
            state_d    = IDLE;
            skew_act_d = 1'b0;
          end else if (tmo_q == TIMEOUT_W'(1)) begin
            tout_d     = 1'b1;
            state_d    = IDLE;
            skew_act_d = 1'b0;
          end else if (first_edge || skew_act_q) begin
            skew_act_d = 1'b1;
            skew_cnt_d = skew_k + SW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      pat_q      <= '0;
      len_q      <= '0;
      fill_q     <= '0;
      tmo_q      <= '0;
      skew_act_q <= 1'b0;
      skew_cnt_q <= '0;
      lane_q     <= '0;
      det_q      <= 1'b0;
      serr_q     <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      fill_q     <= fill_d;
      tmo_q      <= tmo_d;
      skew_act_q <= skew_act_d;
      skew_cnt_q <= skew_cnt_d;
      lane_q     <= lane_d;
      det_q      <= det_d;
      serr_q     <= serr_d;
      tout_q     <= tout_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int n = 0; n < NUM_LANES; n++) shift_q[n] <= '0;
    end else if (shift_clr) begin
      for (int n = 0; n < NUM_LANES; n++) shift_q[n] <= '0;
    end else if (shift_en) begin
      for (int n = 0; n < NUM_LANES; n++) shift_q[n] <= {shift_q[n][MAX_LEN-3:0], dqs_i[n]};
    end
  end

  assign pattern_detected_o = det_q;
  assign lane_detected_o    = lane_q;
  assign skew_err_o         = serr_q;
  assign timeout_o          = tout_q;
  assign busy_o             = (state_q == HUNT);

`ifdef DQS_DET_STATS_EN
  logic [15:0] match_cnt_q, skew_err_cnt_q, timeout_cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      match_cnt_q    <= '0;
      skew_err_cnt_q <= '0;
      timeout_cnt_q  <= '0;
    end else begin
      if (det_d && (match_cnt_q != 16'hFFFF))     match_cnt_q    <= match_cnt_q + 16'd1;
      if (serr_d && (skew_err_cnt_q != 16'hFFFF)) skew_err_cnt_q <= skew_err_cnt_q + 16'd1;
      if (tout_d && (timeout_cnt_q != 16'hFFFF))  timeout_cnt_q  <= timeout_cnt_q + 16'd1;
    end
  end

  assign match_cnt_o    = match_cnt_q;
  assign skew_err_cnt_o = skew_err_cnt_q;
  assign timeout_cnt_o  = timeout_cnt_q;
`endif

endmodule

// File: tb/tb_dqs_preamble_detector_mc.sv
// Directed bench for dqs_preamble_detector_mc: vector table plus hand-written multi-cycle sequences.
module tb_dqs_preamble_detector_mc;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        en_i;
  logic [1:0]  dqs_i;
  logic [2:0]  pre_amble_sett_i;
  logic [15:0] pattern_i;
  logic [4:0]  len_i;
  logic [7:0]  timeout_i;
  logic        pattern_detected_o;
  logic [1:0]  lane_detected_o;
  logic        skew_err_o;
  logic        timeout_o;
  logic        busy_o;
`ifdef DQS_DET_STATS_EN
  logic [15:0] match_cnt_o, skew_err_cnt_o, timeout_cnt_o;
`endif

  dqs_preamble_detector_mc dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .en_i               (en_i),
    .dqs_i              (dqs_i),
    .pre_amble_sett_i   (pre_amble_sett_i),
    .pattern_i          (pattern_i),
    .len_i              (len_i),
    .timeout_i          (timeout_i),
    .pattern_detected_o (pattern_detected_o),
    .lane_detected_o    (lane_detected_o),
    .skew_err_o         (skew_err_o),
    .timeout_o          (timeout_o),
    .busy_o             (busy_o)
`ifdef DQS_DET_STATS_EN
    ,
    .match_cnt_o        (match_cnt_o),
    .skew_err_cnt_o     (skew_err_cnt_o),
    .timeout_cnt_o      (timeout_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       en;
    logic [1:0] dqs;
    logic [2:0] mode;
    logic [5:0] exp;   // {det, lane[1:0], skew_err, timeout, busy}
  } vec_t;

  vec_t vt[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [5:0] outs();
    return {pattern_detected_o, lane_detected_o, skew_err_o, timeout_o, busy_o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic add_v(input logic en, input logic [1:0] dqs, input logic [2:0] mode,
                       input logic [5:0] exp);
    vec_t v;
    v.en = en; v.dqs = dqs; v.mode = mode; v.exp = exp;
    vt.push_back(v);
  endtask

  logic [11:0] cpat;
  logic        bad;

  initial begin
    reset_i = 1'b1; en_i = 1'b0; dqs_i = 2'b00; pre_amble_sett_i = 3'b000;
    pattern_i = 16'h0; len_i = 5'd0; timeout_i = 8'd0;

    // mode 001, both lanes 0,0,1,0
    add_v(1, 2'b00, 3'b001, 6'b000001);
    add_v(1, 2'b00, 3'b001, 6'b000001);
    add_v(1, 2'b00, 3'b001, 6'b000001);
    add_v(1, 2'b11, 3'b001, 6'b000001);
    add_v(1, 2'b00, 3'b001, 6'b111000);
    add_v(0, 2'b00, 3'b001, 6'b011000);
    // mode 000, lane1 matches two edges after lane0: detect
    add_v(1, 2'b00, 3'b000, 6'b000001);
    add_v(1, 2'b01, 3'b000, 6'b000001);
    add_v(1, 2'b00, 3'b000, 6'b001001);
    add_v(1, 2'b10, 3'b000, 6'b001001);
    add_v(1, 2'b00, 3'b000, 6'b111000);
    add_v(0, 2'b00, 3'b000, 6'b011000);
    // mode 000, lane1 three edges late: skew error, flags cleared on re-arm
    add_v(1, 2'b00, 3'b000, 6'b000001);
    add_v(1, 2'b01, 3'b000, 6'b000001);
    add_v(1, 2'b00, 3'b000, 6'b001001);
    add_v(1, 2'b00, 3'b000, 6'b001001);
    add_v(1, 2'b10, 3'b000, 6'b001100);
    add_v(1, 2'b00, 3'b000, 6'b000001);
    // abort on the edge lane0 would have matched
    add_v(1, 2'b01, 3'b000, 6'b000001);
    add_v(0, 2'b00, 3'b000, 6'b000000);
    add_v(0, 2'b00, 3'b000, 6'b000000);
    // mode 011: early "10" over zero history ignored, then full stream
    add_v(1, 2'b00, 3'b011, 6'b000001);
    add_v(1, 2'b11, 3'b011, 6'b000001);
    add_v(1, 2'b00, 3'b011, 6'b000001);
    for (int i = 0; i < 4; i++) add_v(1, 2'b00, 3'b011, 6'b000001);
    add_v(1, 2'b11, 3'b011, 6'b000001);
    add_v(1, 2'b00, 3'b011, 6'b111000);
    // mode 100: 0,0,0,0,1,0,1,0
    add_v(1, 2'b00, 3'b100, 6'b000001);
    for (int i = 0; i < 4; i++) add_v(1, 2'b00, 3'b100, 6'b000001);
    add_v(1, 2'b11, 3'b100, 6'b000001);
    add_v(1, 2'b00, 3'b100, 6'b000001);
    add_v(1, 2'b11, 3'b100, 6'b000001);
    add_v(1, 2'b00, 3'b100, 6'b111000);
    add_v(0, 2'b00, 3'b100, 6'b011000);

    #12;
    chk("reset_state", {26'd0, outs()}, 32'd0);
    reset_i = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      en_i = vt[i].en; dqs_i = vt[i].dqs; pre_amble_sett_i = vt[i].mode;
      step();
      chk($sformatf("vec%0d", i), {26'd0, outs()}, {26'd0, vt[i].exp});
    end

    // timeout after exactly 5 hunt edges, then re-arm after one idle cycle
    pre_amble_sett_i = 3'b001; timeout_i = 8'd5; dqs_i = 2'b11; en_i = 1'b1;
    step();
    chk("tmo_arm_busy", {31'd0, busy_o}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("tmo_edge%0d", i), {30'd0, timeout_o, busy_o},
          (i == 5) ? 32'b10 : 32'b01);
    end
    step();
    chk("tmo_rearm", {30'd0, timeout_o, busy_o}, 32'b01);
    en_i = 1'b0; step();
    timeout_i = 8'd0; en_i = 1'b1;
    step();
    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (timeout_o || !busy_o) bad = 1'b1;
    end
    chk("tmo_disabled_300", {31'd0, bad}, 32'd0);
    en_i = 1'b0; step();

    // custom 12-bit pattern; mode input changed mid-hunt must be ignored
    cpat = 12'hA5C;
    pre_amble_sett_i = 3'b101; len_i = 5'd12; pattern_i = 16'h0A5C; dqs_i = 2'b00; en_i = 1'b1;
    step();
    pre_amble_sett_i = 3'b000;
    for (int i = 0; i < 12; i++) begin
      dqs_i = {cpat[11-i], cpat[11-i]};
      step();
      chk($sformatf("custom_bit%0d", i), {31'd0, pattern_detected_o}, (i == 11) ? 32'd1 : 32'd0);
    end
    en_i = 1'b0; step();

    // custom length 0 clamps to 2, pattern "10"
    pre_amble_sett_i = 3'b101; len_i = 5'd0; pattern_i = 16'h0002; en_i = 1'b1; dqs_i = 2'b00;
    step();
    dqs_i = 2'b11; step();
    chk("len_clamp_b0", {31'd0, pattern_detected_o}, 32'd0);
    dqs_i = 2'b00; step();
    chk("len_clamp_b1", {31'd0, pattern_detected_o}, 32'd1);
    en_i = 1'b0; step();

    // asynchronous reset mid-hunt with lane0 flag set
    pre_amble_sett_i = 3'b000; en_i = 1'b1; dqs_i = 2'b00;
    step();
    dqs_i = 2'b01; step();
    dqs_i = 2'b00; step();
    chk("pre_reset_lane0", {26'd0, outs()}, 32'b001001);
    #2 reset_i = 1'b1;
    #1 chk("async_reset", {26'd0, outs()}, 32'd0);
    en_i = 1'b0;
    #2 reset_i = 1'b0;
    step();

`ifdef DQS_DET_STATS_EN
    for (int k = 0; k < 3; k++) begin
      pre_amble_sett_i = 3'b000; en_i = 1'b1; dqs_i = 2'b00; step();
      dqs_i = 2'b11; step();
      dqs_i = 2'b00; step();
      en_i = 1'b0; step();
    end
    pre_amble_sett_i = 3'b001; timeout_i = 8'd2; dqs_i = 2'b11; en_i = 1'b1;
    step(); step(); step();
    en_i = 1'b0; step();
    chk("stat_match", {16'd0, match_cnt_o}, 32'd3);
    chk("stat_timeout", {16'd0, timeout_cnt_o}, 32'd1);
    chk("stat_skew", {16'd0, skew_err_cnt_o}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
